mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port on-chip program/data memory between the LC-3 CPU memory interface and the program loader, which writes images into memory before run_i.
- Arbitration uses fixed CPU priority, a loader starvation guard and a loader lock for bursts.
- Commands are registered toward memory. Read returns are tagged so each requester receives only its own read data.
- Sits between slc3 cpu, the program loader and the memory wrapper.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LAT, 2, cycles from a read command on mem_*_o to valid mem_rdata_i (legal values 1..4).
- STARVE_LIM, 3, consecutive contested losses after which the loader wins (legal values 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req_i  in  1  CPU request; held with its fields until cpu_gnt_o.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  CPU address.
- cpu_wdata_i  in  DATA_W  CPU write data.
- cpu_gnt_o  out  1  CPU request accepted this cycle.
- cpu_rvalid_o  out  1  CPU read data valid.
- cpu_rdata_o  out  DATA_W  CPU read data.
- ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i, ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o  same widths and meanings, loader side.
- ldr_lock_i  in  1  loader requests exclusive ownership.
- mem_ce_o  out  1  memory command valid.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data.
- locked_o  out  1  arbiter is in S_LOCK.

Behaviour:
- Reset: all outputs 0, FSM in S_ARB, starve_cnt = 0, tag pipe cleared.
  - Reset is asynchronous. It may assert mid-read; in-flight reads are discarded and no rvalid is produced for them after release.
- Grant timing:
  - Grants are combinational from the current requests and state. At most one gnt_o is high per cycle.
  - The granted command appears on mem_*_o on the next cycle. mem_ce_o is high for exactly one cycle per grant, and back-to-back grants are allowed.
- Read return:
  - A read granted at cycle t is issued at t+1. mem_rdata_i is sampled at t+1+RD_LAT.
  - The matching rvalid_o pulses and rdata_o is driven in that same cycle t+1+RD_LAT. rdata_o is 0 when rvalid_o is low.
  - Writes produce no rvalid.
- In S_ARB:
  - Only one requester active: that requester is granted.
  - Both active and starve_cnt < STARVE_LIM: the CPU is granted and starve_cnt increments.
  - Both active and starve_cnt == STARVE_LIM: the loader is granted and starve_cnt returns to 0.
  - starve_cnt is cleared on any loader grant and whenever ldr_req_i is low.
- S_ARB -> S_LOCK: on a cycle where the loader is granted and ldr_lock_i = 1.
- In S_LOCK:
  - Only the loader can be granted; cpu_gnt_o = 0. locked_o = 1 (registered).
  - S_LOCK -> S_ARB when ldr_lock_i = 0, sampled every cycle. The CPU is eligible in that same cycle.
- Simultaneous events:
  - An rvalid for an older read may coincide with a new grant to either side; both proceed.
  - A CPU read and a loader read in flight return in issue order.
- The tag pipe is RD_LAT deep and 2 bits wide per stage: {valid, owner}.

Decomposition:
- Package lc3_mem_pkg holds:
  - typedef enum logic [1:0] {REQ_NONE, REQ_CPU, REQ_LDR} req_t
  - typedef enum logic {S_ARB, S_LOCK} arb_state_t
  - localparam ADDR_W/DATA_W defaults
- Sub-module rd_tag_pipe: a parameterised RD_LAT-deep shift register of req_t tags with async active-low clear. It outputs the head tag used to steer mem_rdata_i.

Test Plan:
- Reset release, CPU-only traffic: CPU write 0x3000 <- 0x1234, then CPU read 0x3000 -> cpu_gnt_o the same cycle as the request; mem_ce_o one cycle later; cpu_rvalid_o with cpu_rdata_o = 0x1234 exactly RD_LAT + 1 cycles after the read grant; ldr_rvalid_o stays 0.
- Continuous contention, STARVE_LIM = 3: both sides request every cycle -> grant sequence CPU, CPU, CPU, LDR, repeating; no cycle has two grants.
- Loader lock burst: loader holds ldr_lock_i and writes 0x0000..0x0007 while the CPU requests continuously -> eight loader grants, locked_o high through the burst, cpu_gnt_o = 0; the CPU is granted the cycle ldr_lock_i drops.
- Interleaved pipelined reads: CPU reads 0x0010 (value 0xAAAA), then loader reads 0x0011 (value 0x5555) on the next cycle -> cpu_rvalid_o/0xAAAA, then ldr_rvalid_o/0x5555 one cycle later; no cross-delivery.
- Reset mid-read: reset_n pulsed low one cycle after a CPU read grant -> all outputs 0 immediately; no cpu_rvalid_o for that read after release; the next grant proceeds normally.
- RD_LAT = 1 and RD_LAT = 4 parameter sweep: the single-read latency check from the first scenario passes at both values.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and width defaults for the LC-3 memory arbiter
//
// Purpose: requester tags used to steer read returns, arbiter FSM states and
// the default address/data widths of the shared program/data memory.
package lc3_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Owner of an in-flight memory read; REQ_NONE marks an empty tag slot.
  typedef enum logic [1:0] {REQ_NONE, REQ_CPU, REQ_LDR} req_t;

  typedef enum logic {S_ARB, S_LOCK} arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - read-owner tag delay line matching the memory read latency
//
// Purpose: carries the owner of each issued read alongside the memory's own
// read pipeline so the returning data can be steered to the right requester.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low clear; drops all in-flight tags
//   tag_in   in   owner of the read issued to memory this cycle (REQ_NONE if none)
//   head     out  owner of the read whose data is on mem_rdata_i this cycle
module rd_tag_pipe
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  req_t tag_in,
  output req_t head
);

  req_t stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= REQ_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between the LC-3 CPU and the program loader
//
// Purpose: grants one requester per cycle (CPU priority, loader starvation
// guard, loader lock for bursts), registers the winning command toward memory
// and delivers each read return only to the requester that issued it.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU command, held until cpu_gnt_o
//   cpu_gnt_o                     CPU command accepted this cycle (combinational)
//   cpu_rvalid_o, cpu_rdata_o     CPU read return (rdata is 0 when not valid)
//   ldr_*                         same set for the program loader
//   ldr_lock_i                    loader asks for exclusive ownership
//   mem_ce_o/we_o/addr_o/wdata_o  registered memory command
//   mem_rdata_i                   memory read data, RD_LAT cycles after the command
//   locked_o                      arbiter is in S_LOCK (registered)
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              ldr_gnt_o,
  output logic              ldr_rvalid_o,
  output logic [DATA_W-1:0] ldr_rdata_o,
  input  logic              ldr_lock_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              locked_o
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  arb_state_t state;
  logic [3:0] starve_cnt;
  req_t       issue_tag;
  req_t       ret_tag;
  logic       arb_open;
  logic       cpu_win;

  // Dropping ldr_lock_i reopens arbitration in the same cycle, even though
  // the state register still reads S_LOCK.
  assign arb_open = (state == S_ARB) || !ldr_lock_i;
  assign cpu_win  = cpu_req_i && (!ldr_req_i || (starve_cnt < LIM));

  // Grants are gated by reset so every output is low while reset is held.
  assign cpu_gnt_o = reset_n && arb_open && cpu_win;
  assign ldr_gnt_o = reset_n && ldr_req_i && !(arb_open && cpu_win);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ARB;
      locked_o   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (ldr_lock_i && (ldr_gnt_o || state == S_LOCK)) begin
        state    <= S_LOCK;
        locked_o <= 1'b1;
      end else begin
        state    <= S_ARB;
        locked_o <= 1'b0;
      end
      // Counts only contested cycles the loader lost.
      if (!ldr_req_i || ldr_gnt_o) begin
        starve_cnt <= '0;
      end else if (cpu_gnt_o) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      issue_tag   <= REQ_NONE;
    end else begin
      mem_ce_o <= cpu_gnt_o || ldr_gnt_o;
      if (cpu_gnt_o) begin
        mem_we_o    <= cpu_we_i;
        mem_addr_o  <= cpu_addr_i;
        mem_wdata_o <= cpu_wdata_i;
        issue_tag   <= cpu_we_i ? REQ_NONE : REQ_CPU;
      end else if (ldr_gnt_o) begin
        mem_we_o    <= ldr_we_i;
        mem_addr_o  <= ldr_addr_i;
        mem_wdata_o <= ldr_wdata_i;
        issue_tag   <= ldr_we_i ? REQ_NONE : REQ_LDR;
      end else begin
        mem_we_o    <= 1'b0;
        mem_addr_o  <= '0;
        mem_wdata_o <= '0;
        issue_tag   <= REQ_NONE;
      end
    end
  end

  // issue_tag is aligned with the command on mem_*_o; RD_LAT more stages put
  // it alongside the matching mem_rdata_i.
  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (issue_tag),
    .head    (ret_tag)
  );

  assign cpu_rvalid_o = (ret_tag == REQ_CPU);
  assign ldr_rvalid_o = (ret_tag == REQ_LDR);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
  assign ldr_rdata_o  = ldr_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at RD_LAT 2, 1 and 4
module tb_mem_arbiter;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  logic clk = 1'b0;
  logic reset_n;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  logic        cpu_req [3], cpu_we [3], ldr_req [3], ldr_we [3], ldr_lock [3];
  logic [15:0] cpu_addr [3], cpu_wdata [3], ldr_addr [3], ldr_wdata [3];
  logic        cpu_gnt [3], cpu_rvalid [3], ldr_gnt [3], ldr_rvalid [3];
  logic [15:0] cpu_rdata [3], ldr_rdata [3];
  logic        mem_ce [3], mem_we [3], locked [3];
  logic [15:0] mem_addr [3], mem_wdata [3], mem_rdata [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = lat_of(k);

    mem_arbiter #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .RD_LAT     (LAT),
      .STARVE_LIM (3)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_req_i    (cpu_req[k]),
      .cpu_we_i     (cpu_we[k]),
      .cpu_addr_i   (cpu_addr[k]),
      .cpu_wdata_i  (cpu_wdata[k]),
      .cpu_gnt_o    (cpu_gnt[k]),
      .cpu_rvalid_o (cpu_rvalid[k]),
      .cpu_rdata_o  (cpu_rdata[k]),
      .ldr_req_i    (ldr_req[k]),
      .ldr_we_i     (ldr_we[k]),
      .ldr_addr_i   (ldr_addr[k]),
      .ldr_wdata_i  (ldr_wdata[k]),
      .ldr_gnt_o    (ldr_gnt[k]),
      .ldr_rvalid_o (ldr_rvalid[k]),
      .ldr_rdata_o  (ldr_rdata[k]),
      .ldr_lock_i   (ldr_lock[k]),
      .mem_ce_o     (mem_ce[k]),
      .mem_we_o     (mem_we[k]),
      .mem_addr_o   (mem_addr[k]),
      .mem_wdata_o  (mem_wdata[k]),
      .mem_rdata_i  (mem_rdata[k]),
      .locked_o     (locked[k])
    );

    // Memory with LAT-cycle read latency; drives junk when no read returns.
    logic [15:0] mem_arr [256];
    logic [15:0] dly [LAT];
    always @(posedge clk) begin
      if (mem_ce[k] && mem_we[k]) mem_arr[mem_addr[k][7:0]] <= mem_wdata[k];
      dly[0] <= (mem_ce[k] && !mem_we[k]) ? mem_arr[mem_addr[k][7:0]] : 16'hBAD0;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign mem_rdata[k] = dly[LAT-1];
  end

  typedef struct {
    int          inst;
    logic        ldr;
    logic [15:0] data;
    int          due;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] shadow [3][256];
  int          vectors = 0;
  int          errs = 0;

  function automatic logic [70:0] outs(input int k);
    return {cpu_gnt[k], cpu_rvalid[k], cpu_rdata[k], ldr_gnt[k], ldr_rvalid[k],
            ldr_rdata[k], mem_ce[k], mem_we[k], mem_addr[k], mem_wdata[k], locked[k]};
  endfunction

  // Called at the negedge sample point: checks read returns against the
  // scoreboard, records this cycle's grants, then moves to posedge+1.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      logic        exp_cv, exp_lv;
      logic [15:0] exp_cd, exp_ld;
      exp_cv = 1'b0; exp_lv = 1'b0; exp_cd = '0; exp_ld = '0;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].inst == k && sb[i].due == cycle) begin
          if (sb[i].ldr) begin exp_lv = 1'b1; exp_ld = sb[i].data; end
          else begin exp_cv = 1'b1; exp_cd = sb[i].data; end
          sb.delete(i);
          break;
        end
      end
      vectors++;
      if ({cpu_rvalid[k], cpu_rdata[k], ldr_rvalid[k], ldr_rdata[k]} !==
          {exp_cv, exp_cd, exp_lv, exp_ld}) begin
        errs++;
        $display("FAIL rdret inst%0d cyc%0d: got cpu %b/%h ldr %b/%h, want cpu %b/%h ldr %b/%h",
                 k, cycle, cpu_rvalid[k], cpu_rdata[k], ldr_rvalid[k], ldr_rdata[k],
                 exp_cv, exp_cd, exp_lv, exp_ld);
      end
      if (cpu_req[k] && cpu_gnt[k]) begin
        if (cpu_we[k]) shadow[k][cpu_addr[k][7:0]] = cpu_wdata[k];
        else sb.push_back('{k, 1'b0, shadow[k][cpu_addr[k][7:0]], cycle + 1 + lat_of(k)});
      end
      if (ldr_req[k] && ldr_gnt[k]) begin
        if (ldr_we[k]) shadow[k][ldr_addr[k][7:0]] = ldr_wdata[k];
        else sb.push_back('{k, 1'b1, shadow[k][ldr_addr[k][7:0]], cycle + 1 + lat_of(k)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (outs(k) !== '0) begin
        errs++;
        $display("FAIL reset_outs inst%0d: got %h, want 0", k, outs(k));
      end
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (outs(k) !== '0) begin
        errs++;
        $display("FAIL idle_outs inst%0d: got %h, want 0", k, outs(k));
      end
    end
    tick();
  endtask

  task automatic test_cpu_only(input int k);
    cpu_req[k] = 1'b1; cpu_we[k] = 1'b1; cpu_addr[k] = 16'h3000; cpu_wdata[k] = 16'h1234;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt[k], ldr_gnt[k]} !== 2'b10) begin
      errs++;
      $display("FAIL wr_gnt inst%0d: got %b, want 10", k, {cpu_gnt[k], ldr_gnt[k]});
    end
    tick();
    cpu_we[k] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_ce[k], mem_we[k], mem_addr[k], mem_wdata[k]} !== {1'b1, 1'b1, 16'h3000, 16'h1234}) begin
      errs++;
      $display("FAIL wr_cmd inst%0d: got %b%b %h %h, want 11 3000 1234",
               k, mem_ce[k], mem_we[k], mem_addr[k], mem_wdata[k]);
    end
    vectors++;
    if (cpu_gnt[k] !== 1'b1) begin
      errs++;
      $display("FAIL rd_gnt inst%0d: got %b, want 1", k, cpu_gnt[k]);
    end
    tick();
    cpu_req[k] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_ce[k], mem_we[k], mem_addr[k]} !== {1'b1, 1'b0, 16'h3000}) begin
      errs++;
      $display("FAIL rd_cmd inst%0d: got %b%b %h, want 10 3000", k, mem_ce[k], mem_we[k], mem_addr[k]);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (mem_ce[k] !== 1'b0) begin
      errs++;
      $display("FAIL ce_pulse inst%0d: got %b, want 0", k, mem_ce[k]);
    end
    tick();
    repeat (lat_of(k) + 2) begin @(negedge clk); tick(); end
    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_drained inst%0d: got %0d pending, want 0", k, sb.size());
    end
  endtask

  task automatic test_contention();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 16'h4000; cpu_wdata[0] = 16'h1111;
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b1; ldr_addr[0] = 16'h4100; ldr_wdata[0] = 16'h2222;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_g;
      exp_g = ((i % 4) == 3) ? 2'b01 : 2'b10;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt[0], ldr_gnt[0]} !== exp_g) begin
        errs++;
        $display("FAIL contend_gnt step%0d: got %b, want %b", i, {cpu_gnt[0], ldr_gnt[0]}, exp_g);
      end
      tick();
    end
    cpu_req[0] = 1'b0; ldr_req[0] = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_lock_burst();
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b1; ldr_lock[0] = 1'b1;
    ldr_addr[0] = 16'h0000; ldr_wdata[0] = 16'h1000;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      vectors++;
      if ({cpu_gnt[0], ldr_gnt[0], locked[0]} !== {1'b0, 1'b1, (j >= 1)}) begin
        errs++;
        $display("FAIL lock_burst beat%0d: got gnt %b%b locked %b, want 01 %b",
                 j, cpu_gnt[0], ldr_gnt[0], locked[0], (j >= 1));
      end
      tick();
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 16'h5000; cpu_wdata[0] = 16'hC0DE;
      ldr_addr[0] = 16'(j + 1); ldr_wdata[0] = 16'(16'h1000 + j + 1);
    end
    ldr_lock[0] = 1'b0; ldr_req[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt[0], ldr_gnt[0], locked[0]} !== 3'b101) begin
      errs++;
      $display("FAIL unlock_gnt: got gnt %b%b locked %b, want 10 1", cpu_gnt[0], ldr_gnt[0], locked[0]);
    end
    tick();
    cpu_req[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (locked[0] !== 1'b0) begin
      errs++;
      $display("FAIL unlock_state: got locked %b, want 0", locked[0]);
    end
    tick();
  endtask

  task automatic test_interleaved_reads();
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b1; ldr_addr[0] = 16'h0010; ldr_wdata[0] = 16'hAAAA;
    @(negedge clk);
    tick();
    ldr_addr[0] = 16'h0011; ldr_wdata[0] = 16'h5555;
    @(negedge clk);
    tick();
    ldr_req[0] = 1'b0;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0010;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt[0], ldr_gnt[0]} !== 2'b10) begin
      errs++;
      $display("FAIL il_cpu_gnt: got %b, want 10", {cpu_gnt[0], ldr_gnt[0]});
    end
    tick();
    cpu_req[0] = 1'b0;
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b0; ldr_addr[0] = 16'h0011;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt[0], ldr_gnt[0]} !== 2'b01) begin
      errs++;
      $display("FAIL il_ldr_gnt: got %b, want 01", {cpu_gnt[0], ldr_gnt[0]});
    end
    tick();
    ldr_req[0] = 1'b0;
    repeat (6) begin @(negedge clk); tick(); end
    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL il_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0010;
    @(negedge clk);
    tick();
    cpu_addr[0] = 16'h0011;
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b0; ldr_addr[0] = 16'h0010;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (outs(0) !== '0) begin
      errs++;
      $display("FAIL midreset_outs: got %h, want 0", outs(0));
    end
    sb.delete();
    @(negedge clk);
    tick();
    reset_n = 1'b1; cpu_req[0] = 1'b0; ldr_req[0] = 1'b0;
    repeat (6) begin @(negedge clk); tick(); end
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0011;
    @(negedge clk);
    vectors++;
    if (cpu_gnt[0] !== 1'b1) begin
      errs++;
      $display("FAIL post_reset_gnt: got %b, want 1", cpu_gnt[0]);
    end
    tick();
    cpu_req[0] = 1'b0;
    repeat (6) begin @(negedge clk); tick(); end
    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL post_reset_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      ldr_req[k] = 1'b0; ldr_we[k] = 1'b0; ldr_addr[k] = '0; ldr_wdata[k] = '0;
      ldr_lock[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cpu_only(0);
    test_contention();
    test_lock_burst();
    test_interleaved_reads();
    test_reset_mid_read();
    test_cpu_only(1);
    test_cpu_only(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
